seg_disp_scheduler: RTL
=======================

# seg_disp_scheduler

Sequential owner of the six-digit seven-segment display. It time-shares the display between up to NUM_REQ requesters (effect select, volume, delay time, …) and an optional idle value. Each accepted request is converted from binary to decimal and shown for HOLD_MS milliseconds, then the display reverts to the idle value. The num0..num5 outputs feed the existing per-digit decoders directly: code 0–9 is a digit, code 10 is blank.

## Interface
- NUM_REQ, 3, number of requesters (1..6)
- VAL_W, 20, binary value width
- CLK_HZ, 50_000_000, clock frequency
- HOLD_MS, 2000, overlay display time
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  level request; requester holds it until ack
- req_val  in  NUM_REQ*VAL_W  packed values; slot i = bits [i*VAL_W +: VAL_W]
- ack  out  NUM_REQ  one-cycle one-hot accept pulse
- idle_en  in  1  show idle_val when no overlay is active; otherwise all blank
- idle_val  in  VAL_W  idle value
- num0..num5  out  32 each  digit codes; num0 = least significant digit
- busy  out  1  high in CONV and HOLD
- active_src  out  3  currently displayed source: 0..5 = requester, 6 = idle, 7 = none

## Operation
- Reset values: num0..num5 = 10, ack = 0, busy = 0, active_src = 7, state IDLE, shown_idle invalid.
- States:
  - IDLE: display shows idle content or blank.
  - CONV: sequential double-dabble runs on the latched value.
  - HOLD: overlay is shown while the hold counter runs.
- Arbitration uses fixed priority; the lowest asserted req index wins.
  - Evaluated in IDLE and HOLD only.
  - req is ignored in CONV; a held req is served after CONV finishes.
- Accept: latch req_val slot and source, pulse ack[i], go to CONV.
- HOLD preemption: any req, including the same source, is accepted immediately. The hold time restarts after the new conversion.
- CONV done:
  - Requester source: write digits, active_src = source, go to HOLD.
  - Idle source: write digits, active_src = 6, return to IDLE.
- HOLD expiry: go to IDLE.
  - If idle_en = 1, start an idle refresh.
  - Else write all 10 and set active_src = 7.
- Idle refresh in IDLE, with no req pending, starts a CONV with source idle when either holds:
  - idle_en = 1 and (idle_val ≠ shown_idle, or entering from HOLD, or first cycle after reset)
  - idle_en falling, which writes all 10 directly without conversion.
- Digit formatting:
  - Leading-zero blanking: digits above the most significant nonzero digit = 10.
  - Value 0 shows num0 = 0 and num1..num5 = 10.
  - Values > 999999 saturate to 999999.
- The display is never partially updated. All six outputs change on the same edge, and the previous digits persist throughout CONV.
- Reset mid-conversion or mid-hold returns to reset values on the next edge. A pending ack is dropped.

## Timing
- A req sampled at rising edge E gives ack high for cycle E..E+1.
- Digits update at edge E+VAL_W+2, which is E+22 for the default VAL_W.
- HOLD lasts HOLD_CYC = CLK_HZ/1000*HOLD_MS cycles from the digit update edge.
  - The counter width is $clog2(HOLD_CYC+1).
- Idle refresh latency is also VAL_W+2 cycles from the refresh decision.
- The saturation compare happens at the latch edge and adds no cycles.

## Structure
- disp_pkg:
  - BLANK_CODE = 10
  - digit_t (4-bit)
  - state_t enum {IDLE, CONV, HOLD}
  - SRC_IDLE = 6, SRC_NONE = 7
  - MAX_DEC = 999999
- Sub-module bin2bcd_seq: shift-add-3 converter.
  - Inputs: start, bin[VAL_W-1:0].
  - Outputs: done (one-cycle pulse), bcd[23:0].
  - Latency VAL_W+1 cycles after start.
- The top level holds the arbiter, FSM, hold counter, blanking and output registers.

## Test plan
- Reset, then idle_en = 0: all num = 10, active_src = 7, busy = 0 for 100 cycles.
- req[1] with value 1234 (CLK_HZ = 1000, HOLD_MS = 5):
  - ack = 3'b010 one cycle.
  - num3..num0 = 1,2,3,4 and num5, num4 = 10 at E+22.
  - active_src = 1 held exactly 5 cycles.
  - Then reverts to all 10, active_src = 7.
- req[0] and req[2] asserted together: ack[0] first, value 0 shows num0 = 0 and the rest blank. req[2] is acked in HOLD and preempts, showing its value.
- req[1] asserted during CONV: no ack until CONV completes, then accepted. HOLD restarts with the new value.
- idle_en = 1, idle_val = 42: shows 4,2 with active_src = 6. A change to 1048575 shows 999999. An overlay then expires and 999999 is restored.
- rst_n low mid-HOLD: next edge all num = 10, ack = 0, state IDLE. A request before HOLD expiry is never shown partially.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | disp_pkg : shared types and constants for the 7-seg scheduler     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package disp_pkg;
  typedef logic [3:0] digit_t;

  localparam digit_t     BLANK_CODE = 4'd10;
  localparam logic [2:0] SRC_IDLE   = 3'd6;
  localparam logic [2:0] SRC_NONE   = 3'd7;
  localparam int         MAX_DEC    = 999999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | bin2bcd_seq : sequential shift-add-3 binary to 6-digit BCD        |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int VAL_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             done,
  output logic [23:0]      bcd
);
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] r_bin;
  logic [23:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;
  logic [23:0]      w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin <= bin;
        r_bcd <= '0;
        r_cnt <= CNT_W'(VAL_W);
        r_run <= 1'b1;
      end else if (r_run) begin
        // Rotate rather than shift: the BCD MSB is always zero for saturated input.
        {r_bcd, r_bin} <= {w_adj[22:0], r_bin, w_adj[23]};
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;
endmodule
`default_nettype wire

// File: rtl/seg_disp_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | seg_disp_scheduler : time-shares the 6-digit display among reqs   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module seg_disp_scheduler
  import disp_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int VAL_W   = 20,
  parameter int CLK_HZ  = 50_000_000,
  parameter int HOLD_MS = 2000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*VAL_W-1:0] req_val,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     idle_en,
  input  logic [VAL_W-1:0]         idle_val,
  output logic [31:0]              num0,
  output logic [31:0]              num1,
  output logic [31:0]              num2,
  output logic [31:0]              num3,
  output logic [31:0]              num4,
  output logic [31:0]              num5,
  output logic                     busy,
  output logic [2:0]               active_src
);
  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
  localparam int EXT_W    = (VAL_W > 20) ? VAL_W : 20;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic [2:0]         r_active;
  logic [2:0]         r_src;
  logic [VAL_W-1:0]   r_val;
  logic [VAL_W-1:0]   r_shown_idle;
  logic               r_shown_valid;
  logic               r_from_hold;
  logic               r_start;
  logic [HOLD_W-1:0]  r_hold;
  digit_t             r_dig [6];

  logic               w_any;
  logic [2:0]         w_win;
  logic [NUM_REQ-1:0] w_onehot;
  logic [VAL_W-1:0]   w_sel_val;
  logic               w_done;
  logic [23:0]        w_bcd;
  digit_t             w_fmt [6];
  logic               w_lz;
  logic               w_refresh;
  logic               w_unshow;

  function automatic logic [VAL_W-1:0] sat(input logic [VAL_W-1:0] v);
    logic [EXT_W-1:0] e;
    e = EXT_W'(v);
    if (e > EXT_W'(MAX_DEC)) return VAL_W'(EXT_W'(MAX_DEC));
    return v;
  endfunction

  always_comb begin
    w_any = 1'b0;
    w_win = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any = 1'b1;
        w_win = 3'(i);
      end
    end
  end

  assign w_onehot  = req & (~req + NUM_REQ'(1));
  assign w_sel_val = req_val[int'(w_win)*VAL_W +: VAL_W];
  assign w_refresh = idle_en && (!r_shown_valid || (idle_val != r_shown_idle) || r_from_hold);
  assign w_unshow  = !idle_en && (r_active == SRC_IDLE);

  // Leading-zero blanking; num0 always shows a digit.
  always_comb begin
    w_lz = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_lz = 1'b0;
      w_fmt[i] = w_lz ? BLANK_CODE : w_bcd[4*i +: 4];
    end
    w_fmt[0] = w_bcd[3:0];
  end

  bin2bcd_seq #(.VAL_W(VAL_W)) u_b2b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (r_start),
    .bin   (r_val),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ack         <= '0;
      r_busy        <= 1'b0;
      r_active      <= SRC_NONE;
      r_src         <= SRC_NONE;
      r_val         <= '0;
      r_shown_idle  <= '0;
      r_shown_valid <= 1'b0;
      r_from_hold   <= 1'b0;
      r_start       <= 1'b0;
      r_hold        <= '0;
      for (int i = 0; i < 6; i++) r_dig[i] <= BLANK_CODE;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      if (w_any && (r_state != CONV)) begin
        r_ack   <= w_onehot;
        r_val   <= sat(w_sel_val);
        r_src   <= w_win;
        r_start <= 1'b1;
        r_busy  <= 1'b1;
        r_state <= CONV;
      end else begin
        case (r_state)
          IDLE: begin
            r_from_hold <= 1'b0;
            if (w_refresh) begin
              r_val        <= sat(idle_val);
              r_shown_idle <= idle_val;
              r_src        <= SRC_IDLE;
              r_start      <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= CONV;
            end else if (w_unshow) begin
              for (int i = 0; i < 6; i++) r_dig[i] <= BLANK_CODE;
              r_active      <= SRC_NONE;
              r_shown_valid <= 1'b0;
            end
          end
          CONV: begin
            if (w_done) begin
              r_dig    <= w_fmt;
              r_active <= r_src;
              if (r_src == SRC_IDLE) begin
                r_shown_valid <= 1'b1;
                r_busy        <= 1'b0;
                r_state       <= IDLE;
              end else begin
                r_shown_valid <= 1'b0;
                r_hold        <= HOLD_W'(HOLD_CYC - 1);
                r_state       <= HOLD;
              end
            end
          end
          HOLD: begin
            if (r_hold == '0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
              if (idle_en) begin
                r_from_hold <= 1'b1;
              end else begin
                for (int i = 0; i < 6; i++) r_dig[i] <= BLANK_CODE;
                r_active <= SRC_NONE;
              end
            end else begin
              r_hold <= r_hold - HOLD_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign active_src = r_active;
  assign num0       = {28'd0, r_dig[0]};
  assign num1       = {28'd0, r_dig[1]};
  assign num2       = {28'd0, r_dig[2]};
  assign num3       = {28'd0, r_dig[3]};
  assign num4       = {28'd0, r_dig[4]};
  assign num5       = {28'd0, r_dig[5]};
endmodule
`default_nettype wire
